// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache between the MEM stage and
// a 128-bit block memory. Misses stall the pipeline via C_BUSYWAIT.
module data_cache #(
    parameter int INDEX_BITS = 3
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         C_READ,
    input  logic         C_WRITE,
    input  logic [31:0]  C_ADDRESS,
    input  logic [31:0]  C_WRITEDATA,
    input  logic [3:0]   C_BYTEEN,
    output logic [31:0]  C_READDATA,
    output logic         C_BUSYWAIT,
    output logic         M_READ,
    output logic         M_WRITE,
    output logic [27:0]  M_ADDRESS,
    output logic [127:0] M_WRITEDATA,
    input  logic [127:0] M_READDATA,
    input  logic         M_BUSYWAIT
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 28 - INDEX_BITS;

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

    state_t                 state_q;
    logic [LINES-1:0]       valid_q;
    logic [LINES-1:0]       dirty_q;
    logic [TAG_BITS-1:0]    tag_q  [LINES];
    logic [127:0]           data_q [LINES];
    logic [27:0]            miss_addr_q;
    logic                   fill_done_q;
    logic                   m_read_q;
    logic                   m_write_q;
    logic [27:0]            m_addr_q;
    logic [127:0]           m_wdata_q;

    logic [INDEX_BITS-1:0]  idx;
    logic [INDEX_BITS-1:0]  fill_idx;
    logic [TAG_BITS-1:0]    tag;
    logic [1:0]             word;
    logic                   req;
    logic                   hit;
    logic [127:0]           line_d;

    assign idx      = C_ADDRESS[INDEX_BITS+3:4];
    assign tag      = C_ADDRESS[31:INDEX_BITS+4];
    assign word     = C_ADDRESS[3:2];
    assign fill_idx = miss_addr_q[INDEX_BITS-1:0];
    assign req      = C_READ | C_WRITE;
    assign hit      = req & valid_q[idx] & (tag_q[idx] == tag);

    // The replay cycle after a fill still reports busy so the CPU sees the
    // request complete on the following hit cycle.
    assign C_BUSYWAIT = (state_q != IDLE) | fill_done_q | (req & ~hit);
    assign C_READDATA = (C_READ & ~C_WRITE & hit) ? data_q[idx][{word, 5'b0} +: 32] : 32'd0;

    assign M_READ      = m_read_q;
    assign M_WRITE     = m_write_q;
    assign M_ADDRESS   = m_addr_q;
    assign M_WRITEDATA = m_wdata_q;

    always_comb begin
        line_d = data_q[idx];
        for (int b = 0; b < 4; b++) begin
            if (C_BYTEEN[b]) begin
                line_d[{word, 5'b0} + 7'(8 * b) +: 8] = C_WRITEDATA[8*b +: 8];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            dirty_q     <= '0;
            miss_addr_q <= '0;
            fill_done_q <= 1'b0;
            m_read_q    <= 1'b0;
            m_write_q   <= 1'b0;
            m_addr_q    <= '0;
            m_wdata_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    fill_done_q <= 1'b0;
                    if (hit && C_WRITE) begin
                        data_q[idx]  <= line_d;
                        dirty_q[idx] <= 1'b1;
                    end else if (req && !hit) begin
                        // Latch the miss so a withdrawn request still completes its fill.
                        miss_addr_q <= C_ADDRESS[31:4];
                        if (valid_q[idx] && dirty_q[idx]) begin
                            state_q   <= WRITEBACK;
                            m_write_q <= 1'b1;
                            m_addr_q  <= {tag_q[idx], idx};
                            m_wdata_q <= data_q[idx];
                        end else begin
                            state_q  <= ALLOCATE;
                            m_read_q <= 1'b1;
                            m_addr_q <= C_ADDRESS[31:4];
                        end
                    end
                end
                WRITEBACK: begin
                    if (!M_BUSYWAIT) begin
                        state_q   <= ALLOCATE;
                        m_write_q <= 1'b0;
                        m_read_q  <= 1'b1;
                        m_addr_q  <= miss_addr_q;
                    end
                end
                ALLOCATE: begin
                    if (!M_BUSYWAIT) begin
                        data_q[fill_idx]  <= M_READDATA;
                        tag_q[fill_idx]   <= miss_addr_q[27:INDEX_BITS];
                        valid_q[fill_idx] <= 1'b1;
                        dirty_q[fill_idx] <= 1'b0;
                        m_read_q          <= 1'b0;
                        fill_done_q       <= 1'b1;
                        state_q           <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: a flat reference memory predicts every load
// and every victim write-back; stall counts and strobe behaviour are checked directly.
module tb_data_cache;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         c_read, c_write;
    logic [31:0]  c_address, c_writedata;
    logic [3:0]   c_byteen;
    logic [31:0]  c_readdata;
    logic         c_busywait;
    logic         m_read, m_write;
    logic [27:0]  m_address;
    logic [127:0] m_writedata;
    logic [127:0] m_readdata;
    logic         m_busywait;

    data_cache #(.INDEX_BITS(3)) dut (
        .CLK(clk), .RESET(reset_n),
        .C_READ(c_read), .C_WRITE(c_write), .C_ADDRESS(c_address),
        .C_WRITEDATA(c_writedata), .C_BYTEEN(c_byteen),
        .C_READDATA(c_readdata), .C_BUSYWAIT(c_busywait),
        .M_READ(m_read), .M_WRITE(m_write), .M_ADDRESS(m_address),
        .M_WRITEDATA(m_writedata), .M_READDATA(m_readdata), .M_BUSYWAIT(m_busywait)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    logic [127:0] mem       [logic [27:0]];
    logic [127:0] model_mem [logic [27:0]];
    logic [31:0]  exp_q [$];

    function automatic logic [127:0] dflt(input logic [27:0] a);
        return {4{4'hA, a}} ^ {32'h0, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
    endfunction
    function automatic logic [127:0] mem_rd(input logic [27:0] a);
        return mem.exists(a) ? mem[a] : dflt(a);
    endfunction
    function automatic logic [127:0] model_rd(input logic [27:0] a);
        return model_mem.exists(a) ? model_mem[a] : dflt(a);
    endfunction

    // Memory model: M_BUSYWAIT is held high for lat_* cycles at the start of each transfer.
    int          lat_rd = 0, lat_wr = 0;
    int          busy_cnt = 0;
    logic [1:0]  key, prev_key = 2'b00;
    logic [27:0] prev_addr = '0;
    int          both_high = 0, addr_unstable = 0, rd_cycles = 0, wb_done = 0;
    logic [27:0] last_rd_addr, last_wr_addr;

    always @(negedge clk) begin
        key = {m_read, m_write};
        if (key == 2'b00) begin
            busy_cnt   = 0;
            m_busywait = 1'b0;
        end else begin
            if (key != prev_key) busy_cnt = 0;
            else if (m_address != prev_addr) addr_unstable++;
            m_busywait = busy_cnt < (m_read ? lat_rd : lat_wr);
            busy_cnt++;
        end
        if (m_read && m_write) both_high++;
        if (m_read) begin
            rd_cycles++;
            last_rd_addr = m_address;
        end
        if (m_write && !m_busywait && reset_n) begin
            check("wb_data", m_writedata, model_rd(m_address));
            mem[m_address] = m_writedata;
            last_wr_addr   = m_address;
            wb_done++;
        end
        m_readdata = mem_rd(m_address);
        prev_key   = key;
        prev_addr  = m_address;
    end

    task automatic cpu_access(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [31:0] data, input logic [3:0] ben, output int stall);
        logic [127:0] blk;
        logic [31:0]  exp;
        blk = model_rd(addr[31:4]);
        c_read = rd; c_write = wr; c_address = addr; c_writedata = data; c_byteen = ben;
        if (wr) begin
            for (int b = 0; b < 4; b++)
                if (ben[b]) blk[32*addr[3:2] + 8*b +: 8] = data[8*b +: 8];
            model_mem[addr[31:4]] = blk;
        end else if (rd) begin
            exp_q.push_back(blk[32*addr[3:2] +: 32]);
        end
        stall = 0;
        @(negedge clk);
        while (c_busywait && stall < 200) begin
            stall++;
            @(negedge clk);
        end
        if (stall >= 200) check("busy_timeout", 1'b1, 1'b0);
        if (rd && !wr) begin
            exp = exp_q.pop_front();
            check("rdata", c_readdata, exp);
        end else begin
            check("rdata_on_write", c_readdata, 32'd0);
        end
        @(posedge clk); #1;
        c_read = 1'b0; c_write = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int stall, rc0, wb0, n;
    logic [127:0] blk4;

    initial begin
        reset_n = 1'b0; c_read = 0; c_write = 0; c_address = 0; c_writedata = 0; c_byteen = 0;
        blk4 = {32'h4444_3333, 32'h4444_2222, 32'hAAAA_AAAA, 32'hDEAD_BEEF};
        mem[28'h4] = blk4;
        model_mem[28'h4] = blk4;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busywait", c_busywait, 1'b0);
        check("rst_m_read", m_read, 1'b0);
        check("rst_m_write", m_write, 1'b0);
        check("rst_m_address", m_address, 28'h0);
        check("rst_m_writedata", m_writedata, 128'h0);
        check("rst_readdata", c_readdata, 32'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // clean read miss, then a hit
        last_rd_addr = '1;
        cpu_access(1, 0, 32'h0000_0040, 0, 0, stall);
        check("miss_stall", stall, 3);
        check("miss_m_addr", last_rd_addr, 28'h4);
        rc0 = rd_cycles;
        cpu_access(1, 0, 32'h0000_0040, 0, 0, stall);
        check("hit_stall", stall, 0);
        check("hit_no_fetch", rd_cycles - rc0, 0);

        // partial write hit
        cpu_access(0, 1, 32'h0000_0044, 32'h1234_5678, 4'b0011, stall);
        check("wr_hit_stall", stall, 0);
        cpu_access(1, 0, 32'h0000_0044, 0, 0, stall);
        check("wr_hit_readback", c_readdata, 32'hAAAA_5678);

        // conflicting read evicts the dirty line
        wb0 = wb_done;
        cpu_access(1, 0, 32'h0000_0440, 0, 0, stall);
        check("dirty_stall", stall, 4);
        check("wb_count", wb_done - wb0, 1);
        check("wb_m_addr", last_wr_addr, 28'h4);
        check("alloc_m_addr", last_rd_addr, 28'h44);

        // stretched fetch
        lat_rd = 5;
        cpu_access(1, 0, 32'h0000_0840, 0, 0, stall);
        check("slow_stall", stall, 8);

        // reset in the middle of ALLOCATE
        lat_rd = 20;
        c_read = 1'b1; c_address = 32'h0000_0880;
        n = 0;
        @(negedge clk);
        while (!m_read && n < 10) begin n++; @(negedge clk); end
        check("mid_rst_fetch_started", m_read, 1'b1);
        @(posedge clk); #1;
        reset_n = 1'b0; c_read = 1'b0;
        @(negedge clk);
        check("mid_rst_m_read", m_read, 1'b1);
        @(negedge clk);
        check("mid_rst_m_read_drop", m_read, 1'b0);
        check("mid_rst_busywait", c_busywait, 1'b0);
        check("mid_rst_m_addr", m_address, 28'h0);
        model_mem = mem;
        @(posedge clk); #1;
        reset_n = 1'b1;
        lat_rd = 5;
        cpu_access(1, 0, 32'h0000_0880, 0, 0, stall);
        check("post_rst_miss_stall", stall, 8);

        // read and write together on a hit behave as a write
        lat_rd = 0;
        cpu_access(1, 1, 32'h0000_0880, 32'hCAFE_F00D, 4'hF, stall);
        check("rw_stall", stall, 0);
        cpu_access(1, 0, 32'h0000_0880, 0, 0, stall);

        // dirty store miss: write-back, fetch, merge on replay
        lat_wr = 2;
        wb0 = wb_done;
        cpu_access(0, 1, 32'h0000_0C84, 32'h5566_7788, 4'b1100, stall);
        check("wr_miss_stall", stall, 6);
        check("wr_miss_wb", wb_done - wb0, 1);
        check("wr_miss_wb_addr", last_wr_addr, 28'h88);
        cpu_access(1, 0, 32'h0000_0C84, 0, 0, stall);
        cpu_access(1, 0, 32'h0000_0C80, 0, 0, stall);
        check("wr_miss_readback_stall", stall, 0);

        check("strobes_both_high", both_high, 0);
        check("m_addr_unstable", addr_unstable, 0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
